fault_campaign_ctrl: RTL and testbench
======================================

Name: fault_campaign_ctrl

Overview:
- Sequencer for stuck-at fault-injection campaigns over a netlist built from fault-injectable library cells. Each cell pin has a stuck_0/stuck_1 control.
- Walks every fault (site x polarity) one at a time. Per fault: restarts the stimulus source, lets the design settle, then watches a golden-vs-faulty mismatch flag.
- Tallies detected and undetected faults for coverage. Sits between the testbench stimulus/compare logic and the per-pin stuck controls.

Parameters:
- NSITES, 16, number of fault sites (pins); total faults NF = 2*NSITES.
- SETTLE, 4, cycles after fault application during which mismatch is ignored; must be >= 1.
- OBSERVE, 8, cycles during which mismatch is sampled; must be >= 1.
- CW, 8, width of the detected/undetected counters; must satisfy 2^CW > NF.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, begin campaign; sampled only in IDLE.
- abort, input, 1, terminate campaign from any state.
- mismatch, input, 1, golden/faulty output compare result.
- stim_restart, output, 1, one-cycle pulse telling the stimulus generator to restart its sequence.
- stuck0, output, NSITES, one-hot (or zero) stuck-at-0 enables.
- stuck1, output, NSITES, one-hot (or zero) stuck-at-1 enables.
- cur_fault, output, clog2(NF), index of the fault under test.
- busy, output, 1, high in any state except IDLE.
- done, output, 1, one-cycle pulse at campaign end.
- det_cnt, output, CW, number of detected faults.
- undet_cnt, output, CW, number of undetected faults.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0: stuck0, stuck1, cur_fault, det_cnt, undet_cnt, stim_restart, busy, done. Internal cycle counter and sticky flag cleared.
- Fault decode: site = cur_fault>>1; polarity = cur_fault[0] (0 = stuck-at-0, 1 = stuck-at-1).
- At most one bit across stuck0|stuck1 is ever high. The enables are registered.
- IDLE: on start=1 and abort=0, clear det_cnt, undet_cnt and cur_fault, then go to ARM. start is ignored outside IDLE.
- ARM (1 cycle):
  - stim_restart=1.
  - The stuck bit for cur_fault is set; it is visible from this cycle.
  - Sticky flag cleared; cycle counter loaded with SETTLE-1. Go to SETTLE.
- SETTLE: mismatch ignored. Counter decrements each cycle; at 0, load OBSERVE-1 and go to OBSERVE.
- OBSERVE:
  - sticky |= mismatch every cycle, including the last.
  - Counter decrements; at 0, go to RECORD.
- RECORD (1 cycle):
  - If sticky is set, det_cnt+1; otherwise undet_cnt+1.
  - stuck0 and stuck1 are cleared this cycle.
  - If cur_fault==NF-1, go to DONE. Otherwise cur_fault+1 and go to ARM.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. Counters and cur_fault hold until the next start.
- Per-fault latency = SETTLE+OBSERVE+2 cycles. Campaign latency from start sampled to done = NF*(SETTLE+OBSERVE+2)+1 cycles.
- Abort: in any state, abort=1 at a clock edge forces IDLE next cycle.
  - stuck0 and stuck1 are cleared; counters and cur_fault hold.
  - No done pulse.
  - abort has priority over start and over every state transition.
- Counters never wrap, guaranteed by the CW constraint. Invariant at done: det_cnt+undet_cnt==NF.
- rst_n asserted mid-campaign: all state and outputs return to reset values immediately; stuck enables drop asynchronously.

Optional Feature:
- Macro: FAULT_LOG_EN.
- Defined:
  - Adds output det_map[NF-1:0]. In RECORD, bit cur_fault is set to sticky.
  - det_map is cleared on reset and on start; it holds after done and after abort.
  - Adds output first_hit[clog2(OBSERVE)-1:0] (minimum width 1). It holds the OBSERVE-cycle offset of the first mismatch for the most recently recorded fault, or 0 if none was seen. It updates in RECORD.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- NSITES=4, SETTLE=2, OBSERVE=3, mismatch tied 0; pulse start -> stim_restart pulses 8 times, 7 cycles apart. done arrives 57 cycles after start sampled, with det_cnt=0 and undet_cnt=8. stuck bits only ever one-hot.
- Same config; mismatch=1 only while stuck1[2] is high -> det_cnt=1, undet_cnt=7. With FAULT_LOG_EN, det_map=8'b0010_0000.
- Mismatch pulsed during SETTLE only, on every fault -> det_cnt=0 (settle window ignored). Mismatch pulsed on the last OBSERVE cycle -> that fault is counted as detected.
- Abort asserted while cur_fault=5 is in OBSERVE -> next cycle IDLE, stuck0=stuck1=0, busy=0, no done pulse. Counters hold their partial values (sum 5).
- start held high during the whole campaign -> exactly one campaign runs and done pulses once. Re-sampling start in IDLE after done clears the counters and reruns.
- rst_n driven low asynchronously mid-ARM with stuck0[1]=1 -> stuck0 goes 0 without waiting for a clock edge. All outputs read 0 after release.

Source files
------------

// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl: sequencer for stuck-at fault-injection campaigns.
// Walks every fault (site x polarity). For each one it restarts the stimulus,
// waits out a settle window, then samples the golden/faulty mismatch flag over
// an observe window and tallies the fault as detected or undetected.
// Optional macro FAULT_LOG_EN adds a per-fault detection map (det_map) and the
// observe-window offset of the first mismatch of the last recorded fault
// (first_hit).
module fault_campaign_ctrl #(
  parameter int NSITES  = 16,
  parameter int SETTLE  = 4,
  parameter int OBSERVE = 8,
  parameter int CW      = 8,
  localparam int NF     = 2 * NSITES,
  localparam int FW     = (NF > 1) ? $clog2(NF) : 1,
  localparam int FHW    = (OBSERVE > 1) ? $clog2(OBSERVE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mismatch,
  output logic              stim_restart,
  output logic [NSITES-1:0] stuck0,
  output logic [NSITES-1:0] stuck1,
  output logic [FW-1:0]     cur_fault,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     det_cnt,
  output logic [CW-1:0]     undet_cnt
`ifdef FAULT_LOG_EN
  ,
  output logic [NF-1:0]     det_map,
  output logic [FHW-1:0]    first_hit
`endif
);

  localparam int MAXWIN = (SETTLE > OBSERVE) ? SETTLE : OBSERVE;
  localparam int CNTW   = $clog2(MAXWIN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_OBSERVE,
    S_RECORD,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [CNTW-1:0]     cnt_q;
  logic                sticky_q;
  logic [FW-1:0]       fault_q;
  logic [NSITES-1:0]   stuck0_q;
  logic [NSITES-1:0]   stuck1_q;
  logic                restart_q;
  logic                busy_q;
  logic                done_q;
  logic [CW-1:0]       det_q;
  logic [CW-1:0]       undet_q;

  // Fault index that the next ARM will inject, and its decoded enables.
  logic [FW-1:0]       arm_fault_d;
  logic [NSITES-1:0]   stuck0_d;
  logic [NSITES-1:0]   stuck1_d;

`ifdef FAULT_LOG_EN
  logic [NF-1:0]       det_map_q;
  logic [FHW-1:0]      first_hit_q;
  logic [FHW-1:0]      hit_off_q;
  logic [FHW-1:0]      hit_off_d;
`endif

  // Decode the fault to be armed next: fault 0 from IDLE, fault+1 from RECORD.
  always_comb begin
    arm_fault_d = (state_q == S_RECORD) ? fault_q + FW'(1) : '0;
    stuck0_d    = '0;
    stuck1_d    = '0;
    for (int i = 0; i < NSITES; i++) begin
      if (int'(arm_fault_d >> 1) == i) begin
        stuck0_d[i] = ~arm_fault_d[0];
        stuck1_d[i] = arm_fault_d[0];
      end
    end
  end

`ifdef FAULT_LOG_EN
  // Offset within the observe window: the counter runs OBSERVE-1 down to 0.
  always_comb begin
    hit_off_d = FHW'(CNTW'(OBSERVE - 1) - cnt_q);
  end
`endif

  // Campaign FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      fault_q   <= '0;
      stuck0_q  <= '0;
      stuck1_q  <= '0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_q     <= '0;
      undet_q   <= '0;
`ifdef FAULT_LOG_EN
      det_map_q   <= '0;
      first_hit_q <= '0;
      hit_off_q   <= '0;
`endif
    end else if (abort) begin
      // Abort wins over start and every transition; tallies and index hold.
      state_q   <= S_IDLE;
      stuck0_q  <= '0;
      stuck1_q  <= '0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      restart_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            det_q     <= '0;
            undet_q   <= '0;
            fault_q   <= '0;
            stuck0_q  <= stuck0_d;
            stuck1_q  <= stuck1_d;
            restart_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_ARM;
`ifdef FAULT_LOG_EN
            det_map_q <= '0;
`endif
          end
        end
        S_ARM: begin
          sticky_q <= 1'b0;
          cnt_q    <= CNTW'(SETTLE - 1);
          state_q  <= S_SETTLE;
`ifdef FAULT_LOG_EN
          hit_off_q <= '0;
`endif
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            cnt_q   <= CNTW'(OBSERVE - 1);
            state_q <= S_OBSERVE;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        S_OBSERVE: begin
          sticky_q <= sticky_q | mismatch;
`ifdef FAULT_LOG_EN
          if (mismatch && !sticky_q) begin
            hit_off_q <= hit_off_d;
          end
`endif
          if (cnt_q == '0) begin
            // Fault is released as the record cycle begins.
            stuck0_q <= '0;
            stuck1_q <= '0;
            state_q  <= S_RECORD;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        S_RECORD: begin
          if (sticky_q) begin
            det_q <= det_q + CW'(1);
          end else begin
            undet_q <= undet_q + CW'(1);
          end
`ifdef FAULT_LOG_EN
          det_map_q[fault_q] <= sticky_q;
          first_hit_q        <= hit_off_q;
`endif
          if (fault_q == FW'(NF - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            fault_q   <= arm_fault_d;
            stuck0_q  <= stuck0_d;
            stuck1_q  <= stuck1_d;
            restart_q <= 1'b1;
            state_q   <= S_ARM;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stim_restart = restart_q;
  assign stuck0       = stuck0_q;
  assign stuck1       = stuck1_q;
  assign cur_fault    = fault_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign det_cnt      = det_q;
  assign undet_cnt    = undet_q;
`ifdef FAULT_LOG_EN
  assign det_map      = det_map_q;
  assign first_hit    = first_hit_q;
`endif

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// Testbench for fault_campaign_ctrl: NSITES=4, SETTLE=2, OBSERVE=3, CW=8.
// Expected campaign results are queued by the stimulus; a monitor pops one
// entry on every done pulse and also checks each stim_restart pulse.
module tb_fault_campaign_ctrl;

  localparam int NSITES  = 4;
  localparam int SETTLE  = 2;
  localparam int OBSERVE = 3;
  localparam int CW      = 8;
  localparam int NF      = 2 * NSITES;
  localparam int PERF    = SETTLE + OBSERVE + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              mismatch = 1'b0;
  logic              stim_restart;
  logic [NSITES-1:0] stuck0;
  logic [NSITES-1:0] stuck1;
  logic [2:0]        cur_fault;
  logic              busy;
  logic              done;
  logic [CW-1:0]     det_cnt;
  logic [CW-1:0]     undet_cnt;
`ifdef FAULT_LOG_EN
  logic [NF-1:0]     det_map;
  logic [1:0]        first_hit;
`endif

  fault_campaign_ctrl #(
    .NSITES (NSITES),
    .SETTLE (SETTLE),
    .OBSERVE(OBSERVE),
    .CW     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mismatch    (mismatch),
    .stim_restart(stim_restart),
    .stuck0      (stuck0),
    .stuck1      (stuck1),
    .cur_fault   (cur_fault),
    .busy        (busy),
    .done        (done),
    .det_cnt     (det_cnt),
    .undet_cnt   (undet_cnt)
`ifdef FAULT_LOG_EN
    ,
    .det_map     (det_map),
    .first_hit   (first_hit)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         det;
    int         undet;
    int         restarts;
    logic [7:0] map;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   mode  = 0;
  int   ph    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int d, input int u, input logic [7:0] m);
    exp_t e;
    e.det = d;
    e.undet = u;
    e.restarts = NF;
    e.map = m;
    exp_q.push_back(e);
  endtask

  // Mismatch driver: phase counts cycles since the last restart pulse.
  // Phase 0 = ARM, 1..2 = SETTLE, 3..5 = OBSERVE, 6 = RECORD.
  initial begin
    forever begin
      @(negedge clk);
      if (stim_restart) ph = 0;
      else ph = ph + 1;
      case (mode)
        1: mismatch = stuck1[2];
        2: mismatch = (ph == 1) || (ph == 2);
        3: mismatch = (ph == 5) && (cur_fault == 3'd3);
        default: mismatch = 1'b0;
      endcase
    end
  end

  // Monitor: one-hot enables, restart spacing/decode, and scoreboard on done.
  initial begin
    int   cyc = 0;
    int   rcount = 0;
    int   last_rs = 0;
    int   site;
    logic [NSITES-1:0] e0, e1;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      check("stuck_onehot", 32'($countones({stuck1, stuck0}) <= 1), 32'd1);
      if (stim_restart) begin
        site = int'(cur_fault >> 1);
        e0 = '0;
        e1 = '0;
        if (cur_fault[0]) e1[site] = 1'b1;
        else e0[site] = 1'b1;
        check("restart_stuck0", 32'(stuck0), 32'(e0));
        check("restart_stuck1", 32'(stuck1), 32'(e1));
        check("restart_fault_seq", 32'(cur_fault), 32'(rcount));
        if (rcount > 0) check("restart_gap", 32'(cyc - last_rs), 32'(PERF));
        last_rs = cyc;
        rcount++;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_det_cnt", 32'(det_cnt), 32'(e.det));
          check("done_undet_cnt", 32'(undet_cnt), 32'(e.undet));
          check("done_restarts", 32'(rcount), 32'(e.restarts));
          check("done_busy", 32'(busy), 32'd0);
          check("done_sum", 32'(det_cnt) + 32'(undet_cnt), 32'(NF));
`ifdef FAULT_LOG_EN
          check("done_det_map", 32'(det_map), 32'(e.map));
          check("done_first_hit", 32'(first_hit), 32'd0);
`endif
        end
      end else if (!busy) begin
        rcount = 0;
      end
    end
  end

  // Run one campaign from IDLE; done must appear in cycle 57 (ARM = cycle 1).
  task automatic run_campaign(input bit hold);
    int  cyc;
    bit  got;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    check("campaign_latency", got ? 32'(cyc) : 32'd0, 32'(NF * PERF + 1));
  endtask

  // Wait (bounded) for a restart pulse of a given fault, at a negedge.
  task automatic wait_restart(input int f, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (stim_restart && (cur_fault == 3'(f))) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_restart_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stuck", 32'({stuck1, stuck0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_restart", 32'(stim_restart), 32'd0);
    check("rst_cur_fault", 32'(cur_fault), 32'd0);
    check("rst_cnts", 32'({det_cnt, undet_cnt}), 32'd0);

    // No mismatch: all 8 undetected.
    mode = 0;
    push_exp(0, 8, 8'h00);
    run_campaign(1'b0);

    // Mismatch only while stuck1[2] (fault 5) is applied.
    mode = 1;
    push_exp(1, 7, 8'h20);
    run_campaign(1'b0);

    // Mismatch only in the settle window: ignored.
    mode = 2;
    push_exp(0, 8, 8'h00);
    run_campaign(1'b0);

    // Mismatch on the last observe cycle of fault 3: detected.
    mode = 3;
    push_exp(1, 7, 8'h08);
    run_campaign(1'b0);

    // Abort while fault 5 is in its first observe cycle.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_restart(5, ok);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stuck", 32'({stuck1, stuck0}), 32'd0);
    check("abort_cur_fault", 32'(cur_fault), 32'd5);
    check("abort_undet", 32'(undet_cnt), 32'd5);
    check("abort_det", 32'(det_cnt), 32'd0);
    repeat (15) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);

    // start held through the whole campaign: one run, then rerun clears.
    mode = 1;
    push_exp(1, 7, 8'h20);
    run_campaign(1'b1);
    repeat (10) @(negedge clk);
    check("held_start_idle", 32'(busy), 32'd0);
    check("held_start_fault_hold", 32'(cur_fault), 32'd7);
    check("held_start_det_hold", 32'(det_cnt), 32'd1);
    mode = 0;
    push_exp(0, 8, 8'h00);
    run_campaign(1'b0);

    // Asynchronous reset during ARM of fault 2 (stuck0[1]).
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_restart(2, ok);
    check("pre_rst_stuck0", 32'(stuck0), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stuck0", 32'(stuck0), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_outs", 32'({stim_restart, busy, done, cur_fault, stuck1, stuck0}), 32'd0);
    check("post_rst_cnts", 32'({det_cnt, undet_cnt}), 32'd0);
`ifdef FAULT_LOG_EN
    check("post_rst_log", 32'({det_map, first_hit}), 32'd0);
`endif
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
